// File: rtl/hit_info_queue_pp_if.sv
// Handshake and status bundle between the SSID front end, the hit-info queue and its HNMPP-driven consumer.
// The producer/consumer side uses the master modport, the queue itself uses slave.
interface hit_info_queue_pp_if #(
  parameter int DATABITS  = 16,
  parameter int DEPTHBITS = 4,
  parameter int DROPBITS  = 8
);
  logic                 flush;
  logic                 clear_err;
  logic                 push;
  logic [DATABITS-1:0]  push_data;
  logic                 pop;
  logic [DATABITS-1:0]  head_data;
  logic                 empty;
  logic                 full;
  logic                 almost_full;
  logic [DEPTHBITS:0]   count;
  logic [DEPTHBITS:0]   peak_count;
  logic                 overflow;
  logic                 underflow;
  logic [DROPBITS-1:0]  drop_count;

  modport master (
    output flush, clear_err, push, push_data, pop,
    input  head_data, empty, full, almost_full, count, peak_count,
           overflow, underflow, drop_count
  );

  modport slave (
    input  flush, clear_err, push, push_data, pop,
    output head_data, empty, full, almost_full, count, peak_count,
           overflow, underflow, drop_count
  );
endinterface

// File: rtl/hit_info_queue_pp.sv
// Circular-buffer hit-info queue holding each word until its SSID emerges from HNMPP.
// Show-ahead head, protected overflow/underflow, flush, saturating drop counter and peak monitor.
module hit_info_queue_pp #(
  parameter int DATABITS    = 16,
  parameter int DEPTH       = 16,
  parameter int DEPTHBITS   = 4,
  parameter int AFULL_LEVEL = 12,
  parameter int DROPBITS    = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  hit_info_queue_pp_if.slave  bus
);

  localparam logic [DEPTHBITS:0]   LP_DEPTH   = (DEPTHBITS+1)'(DEPTH);
  localparam logic [DEPTHBITS:0]   LP_AFULL   = (DEPTHBITS+1)'(AFULL_LEVEL);
  localparam logic [DEPTHBITS:0]   LP_CNTONE  = (DEPTHBITS+1)'(1);
  localparam logic [DEPTHBITS-1:0] LP_PTRONE  = DEPTHBITS'(1);
  localparam logic [DROPBITS-1:0]  LP_DROPONE = DROPBITS'(1);
  localparam logic [DROPBITS-1:0]  LP_DROPMAX = '1;

  logic [DATABITS-1:0]  r_mem [DEPTH];
  logic [DEPTHBITS-1:0] r_wrPtr;
  logic [DEPTHBITS-1:0] r_rdPtr;
  logic [DEPTHBITS:0]   r_count;
  logic [DEPTHBITS:0]   r_peak;
  logic [DROPBITS-1:0]  r_drop;
  logic                 r_overflow;
  logic                 r_underflow;

  logic [DEPTHBITS:0]   w_countNext;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_popEff;
  logic                 w_pushAcc;
  logic                 w_ovfEvent;
  logic                 w_unfEvent;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == LP_DEPTH);
  assign w_popEff   = bus.pop && !w_empty;
  // A pop while full frees the slot being written, so the push is still accepted.
  assign w_pushAcc  = bus.push && (!w_full || w_popEff);
  assign w_ovfEvent = !bus.flush && bus.push && w_full && !bus.pop;
  assign w_unfEvent = !bus.flush && bus.pop && w_empty;

  always_comb begin
    w_countNext = r_count;
    if (bus.flush) begin
      w_countNext = '0;
    end else if (w_pushAcc && !w_popEff) begin
      w_countNext = r_count + LP_CNTONE;
    end else if (!w_pushAcc && w_popEff) begin
      w_countNext = r_count - LP_CNTONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset && !bus.flush && w_pushAcc) begin
      r_mem[r_wrPtr] <= bus.push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_count     <= '0;
      r_peak      <= '0;
      r_drop      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wrPtr <= '0;
        r_rdPtr <= '0;
      end else begin
        if (w_pushAcc) r_wrPtr <= r_wrPtr + LP_PTRONE;
        if (w_popEff)  r_rdPtr <= r_rdPtr + LP_PTRONE;
      end
      r_count <= w_countNext;

      // A same-cycle error event beats clear_err.
      r_overflow  <= w_ovfEvent || (r_overflow  && !bus.clear_err);
      r_underflow <= w_unfEvent || (r_underflow && !bus.clear_err);

      if (bus.clear_err) begin
        r_drop <= w_ovfEvent ? LP_DROPONE : '0;
      end else if (w_ovfEvent && r_drop != LP_DROPMAX) begin
        r_drop <= r_drop + LP_DROPONE;
      end

      if (bus.clear_err || w_countNext > r_peak) begin
        r_peak <= w_countNext;
      end
    end
  end

  assign bus.head_data   = r_mem[r_rdPtr];
  assign bus.empty       = w_empty;
  assign bus.full        = w_full;
  assign bus.almost_full = (r_count >= LP_AFULL);
  assign bus.count       = r_count;
  assign bus.peak_count  = r_peak;
  assign bus.overflow    = r_overflow;
  assign bus.underflow   = r_underflow;
  assign bus.drop_count  = r_drop;

endmodule

// File: tb/tb_hit_info_queue_pp.sv
// Directed bench for hit_info_queue_pp: a queue-based scoreboard predicts every pop and status output.
module tb_hit_info_queue_pp;

  localparam int DATABITS  = 16;
  localparam int DEPTH     = 16;
  localparam int DEPTHBITS = 4;
  localparam int AFULL     = 12;
  localparam int DROPBITS  = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hit_info_queue_pp_if #(.DATABITS(DATABITS), .DEPTHBITS(DEPTHBITS), .DROPBITS(DROPBITS)) bus ();

  hit_info_queue_pp #(
    .DATABITS(DATABITS), .DEPTH(DEPTH), .DEPTHBITS(DEPTHBITS),
    .AFULL_LEVEL(AFULL), .DROPBITS(DROPBITS)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [DATABITS-1:0] sbQ [$];
  int mOvf  = 0;
  int mUnf  = 0;
  int mDrop = 0;
  int mPeak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = sbQ.size();
    chk({tag, ".count"},       32'(bus.count),       32'(n));
    chk({tag, ".empty"},       32'(bus.empty),       32'(n == 0));
    chk({tag, ".full"},        32'(bus.full),        32'(n == DEPTH));
    chk({tag, ".almost_full"}, 32'(bus.almost_full), 32'(n >= AFULL));
    chk({tag, ".overflow"},    32'(bus.overflow),    32'(mOvf));
    chk({tag, ".underflow"},   32'(bus.underflow),   32'(mUnf));
    chk({tag, ".drop_count"},  32'(bus.drop_count),  32'(mDrop));
    chk({tag, ".peak_count"},  32'(bus.peak_count),  32'(mPeak));
    chk({tag, ".count_le_depth"}, 32'(bus.count <= 5'(DEPTH)), 32'(1));
    if (n > 0) chk({tag, ".head"}, 32'(bus.head_data), 32'(sbQ[0]));
  endtask

  task automatic applyStimulus(input logic p, input logic [DATABITS-1:0] d,
                               input logic po, input logic fl, input logic cl);
    bit isEmpty, isFull, popEff, acc, ovf, unf;
    int n;
    bus.push      = p;
    bus.push_data = d;
    bus.pop       = po;
    bus.flush     = fl;
    bus.clear_err = cl;
    isEmpty = (sbQ.size() == 0);
    isFull  = (sbQ.size() == DEPTH);
    popEff  = !fl && po && !isEmpty;
    acc     = !fl && p && (!isFull || (po && !isEmpty));
    ovf     = !fl && p && isFull && !po;
    unf     = !fl && po && isEmpty;
    if (fl) begin
      sbQ.delete();
    end else begin
      if (popEff) begin
        chk("pop.head", 32'(bus.head_data), 32'(sbQ[0]));
        void'(sbQ.pop_front());
      end
      if (acc) sbQ.push_back(d);
    end
    n = sbQ.size();
    mOvf = ovf ? 1 : (cl ? 0 : mOvf);
    mUnf = unf ? 1 : (cl ? 0 : mUnf);
    if (cl) mDrop = ovf ? 1 : 0;
    else if (ovf && mDrop < 255) mDrop++;
    if (cl || n > mPeak) mPeak = n;
    @(posedge clk);
    #1;
    bus.push      = 1'b0;
    bus.pop       = 1'b0;
    bus.flush     = 1'b0;
    bus.clear_err = 1'b0;
  endtask

  task automatic resetDut(input int cycles);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
    sbQ.delete();
    mOvf = 0; mUnf = 0; mDrop = 0; mPeak = 0;
  endtask

  initial begin
    bus.push = 1'b0; bus.push_data = '0; bus.pop = 1'b0;
    bus.flush = 1'b0; bus.clear_err = 1'b0;

    resetDut(2);
    checkOutput("reset");
    applyStimulus(1'b1, 16'h0A01, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0A02, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h0A03, 1'b0, 1'b0, 1'b0);
    checkOutput("first3");
    chk("first3.count_const", 32'(bus.count), 32'd3);
    chk("first3.head_const",  32'(bus.head_data), 32'h0A01);
    chk("first3.peak_const",  32'(bus.peak_count), 32'd3);
    repeat (3) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 16'(16'h1000 + i), 1'b0, 1'b0, 1'b0);
      if (i == 10) chk("fill.af_before", 32'(bus.almost_full), 32'd0);
      if (i == 11) chk("fill.af_at12",   32'(bus.almost_full), 32'd1);
      if (i == 14) chk("fill.full_before", 32'(bus.full), 32'd0);
      if (i == 15) chk("fill.full_at16",   32'(bus.full), 32'd1);
    end
    applyStimulus(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    checkOutput("reject");
    chk("reject.overflow_const", 32'(bus.overflow), 32'd1);
    chk("reject.drop_const",     32'(bus.drop_count), 32'd1);
    chk("reject.count_const",    32'(bus.count), 32'd16);
    repeat (DEPTH) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain1");
    chk("drain1.empty_const", 32'(bus.empty), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear1");

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h3000, 1'b1, 1'b0, 1'b0);
    checkOutput("fullpp");
    chk("fullpp.count_const", 32'(bus.count), 32'd16);
    chk("fullpp.head_const",  32'(bus.head_data), 32'h2001);
    chk("fullpp.ovf_const",   32'(bus.overflow), 32'd0);
    repeat (DEPTH) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain2");

    applyStimulus(1'b1, 16'h4444, 1'b1, 1'b0, 1'b0);
    checkOutput("emptypp");
    chk("emptypp.count_const", 32'(bus.count), 32'd1);
    chk("emptypp.head_const",  32'(bus.head_data), 32'h4444);
    chk("emptypp.unf_const",   32'(bus.underflow), 32'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clear2");
    chk("clear2.unf_const",  32'(bus.underflow), 32'd0);
    chk("clear2.peak_const", 32'(bus.peak_count), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, 16'(16'h6000 + i), 1'(i % 2), 1'b0, 1'b0);
      checkOutput("wrap");
    end
    for (int k = 0; k < 24; k++) begin
      if (sbQ.size() > 0) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("wrapdrain");

    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 16'(16'h7000 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 16'h5555, 1'b0, 1'b1, 1'b0);
    checkOutput("flush");
    chk("flush.count_const", 32'(bus.count), 32'd0);
    chk("flush.empty_const", 32'(bus.empty), 32'd1);
    chk("flush.drop_const",  32'(bus.drop_count), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 16'(16'h8000 + i), 1'b0, 1'b0, 1'b0);
    checkOutput("refill");
    resetDut(1);
    checkOutput("midreset");
    chk("midreset.peak_const",  32'(bus.peak_count), 32'd0);
    chk("midreset.count_const", 32'(bus.count), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
